serial_adder_ctrl: RTL and testbench

Bit-serial addition controller that reuses one `full_adder` instance over `WIDTH` clock cycles to add two `WIDTH`-bit operands, LSB first. It sits between a requesting block and the single-bit adder datapath. It captures operands on a start request, sequences one bit per cycle through the adder while holding the carry in a flop, and presents a registered result with a one-cycle done pulse. It trades latency for area in place of a ripple-carry array.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder.sv | 16 +
 rtl/serial_adder_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder used as the per-bit datapath of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Plain combinational sum and carry.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial addition controller: one full_adder reused over WIDTH cycles,
// operands consumed LSB first, registered result with a one-cycle done pulse.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a - b.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] b_cap;
  logic             c_cap;
  logic             fa_sum;
  logic             fa_cout;

  // The single shared bit-slice adder.
  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Operand B and initial carry as captured; subtraction uses a + ~b + 1.
  always_comb begin
    b_cap = b;
    c_cap = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_cap = ~b;
      c_cap = 1'b1;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and status decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last      = (cnt == LAST);
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-bit shifting and result publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b_cap;
      carry <= c_cap;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= fa_cout;
      res_sr <= {fa_sum, res_sr[WIDTH-1:1]};
      if (last) begin
        // Final bit lands directly in the published result.
        sum  <= {fa_sum, res_sr[WIDTH-1:1]};
        cout <= fa_cout;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH = 8).
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int vecs = 0;
  int errs = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: {cout,sum} = a + b + cin, or a + ~b + 1 for subtraction.
  function automatic logic [W:0] model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                       input logic ic, input logic isub);
    logic [W-1:0] nb;
    logic [W:0]   r;
    nb = ~ib;
    if (isub) r = {1'b0, ia} + {1'b0, nb} + 1;
    else      r = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
    return r;
  endfunction

  task automatic drive(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input logic isub);
    a   = ia;
    b   = ib;
    cin = ic;
`ifdef SERIAL_ADDER_SUB_EN
    sub = isub;
`else
    if (isub) $display("note: sub requested without SERIAL_ADDER_SUB_EN");
`endif
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                        input logic isub, input string nm);
    logic [W:0] exp;
    int n;
    exp = model(ia, ib, ic, isub);
    drive(ia, ib, ic, isub);
    start = 1'b1;
    step();
    start = 1'b0;
    vecs++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL %s busy_after_accept: got %b want 1", nm, busy);
    end
    n = 0;
    while (done !== 1'b1 && n < 4 * W) begin
      step();
      n++;
    end
    vecs++;
    if (n !== W) begin
      errs++;
      $display("FAIL %s latency: got %0d cycles want %0d", nm, n, W);
    end
    vecs++;
    if ({cout, sum} !== exp) begin
      errs++;
      $display("FAIL %s result: got cout=%b sum=%h want cout=%b sum=%h",
               nm, cout, sum, exp[W], exp[W-1:0]);
    end
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL %s busy_at_done: got %b want 0", nm, busy);
    end
    step();
    vecs++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL %s after_done: got done=%b busy=%b want 0 0", nm, done, busy);
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    step();
    step();
    vecs++;
    if ({busy, done, cout, sum} !== '0) begin
      errs++;
      $display("FAIL reset_values: got busy=%b done=%b cout=%b sum=%h want all 0",
               busy, done, cout, sum);
    end
    #2 rst = 1'b0;
    step();
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    run_op(8'h3C, 8'h05, 1'b0, 1'b0, "add_3c_05");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, "add_ff_ff_c1");
  endtask

  task automatic test_start_ignored;
    logic [W:0] old;
    logic [W:0] exp;
    int n;
    old = {cout, sum};
    exp = model(8'h5A, 8'h33, 1'b1, 1'b0);
    drive(8'h5A, 8'h33, 1'b1, 1'b0);
    start = 1'b1;
    step();
    n = 0;
    while (done !== 1'b1 && n < 4 * W) begin
      vecs++;
      if ({cout, sum} !== old) begin
        errs++;
        $display("FAIL ignore_hold: got %h want %h at run cycle %0d", {cout, sum}, old, n);
      end
      start = 1'($urandom);
      drive(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      step();
      n++;
    end
    start = 1'b0;
    vecs++;
    if (n !== W) begin
      errs++;
      $display("FAIL ignore_latency: got %0d want %0d", n, W);
    end
    vecs++;
    if ({cout, sum} !== exp) begin
      errs++;
      $display("FAIL ignore_result: got %h want %h", {cout, sum}, exp);
    end
    step();
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL ignore_idle: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] pa [3];
    logic [W-1:0] pb [3];
    logic         pc [3];
    logic [W:0]   exp;
    int n;
    for (int i = 0; i < 3; i++) begin
      pa[i] = W'($urandom);
      pb[i] = W'($urandom);
      pc[i] = 1'($urandom);
    end
    drive(pa[0], pb[0], pc[0], 1'b0);
    start = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      if (k < 2) drive(pa[k+1], pb[k+1], pc[k+1], 1'b0);
      else       start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 4 * W) begin
        step();
        n++;
      end
      exp = model(pa[k], pb[k], pc[k], 1'b0);
      vecs++;
      if (n !== W) begin
        errs++;
        $display("FAIL b2b_spacing[%0d]: got %0d want %0d", k, n, W);
      end
      vecs++;
      if ({cout, sum} !== exp) begin
        errs++;
        $display("FAIL b2b_result[%0d]: got %h want %h", k, {cout, sum}, exp);
      end
      step();
      vecs++;
      if (done !== 1'b0 || busy !== (k < 2)) begin
        errs++;
        $display("FAIL b2b_after_done[%0d]: got done=%b busy=%b want 0 %b",
                 k, done, busy, (k < 2));
      end
    end
  endtask

  task automatic test_reset_midrun;
    int seen;
    run_op(8'h3C, 8'h05, 1'b0, 1'b0, "pre_reset");
    drive(8'hAA, 8'h77, 1'b1, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    #2 rst = 1'b1;
    #1;
    vecs++;
    if ({busy, done, cout, sum} !== '0) begin
      errs++;
      $display("FAIL midrun_reset: got busy=%b done=%b cout=%b sum=%h want all 0",
               busy, done, cout, sum);
    end
    #2 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < W + 3; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    vecs++;
    if (seen !== 0) begin
      errs++;
      $display("FAIL midrun_discard: got %0d active cycles want 0", seen);
    end
    run_op(8'h10, 8'h20, 1'b0, 1'b0, "post_reset");
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    run_op(8'h05, 8'h07, 1'b1, 1'b1, "sub_05_07");
    run_op(8'h07, 8'h05, 1'b0, 1'b1, "sub_07_05");
    run_op(8'h3C, 8'h05, 1'b0, 1'b0, "sub0_add");
  endtask
`endif

  task automatic test_random;
    logic s;
    for (int i = 0; i < 25; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom), s, "random");
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    test_reset();
    test_directed();
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
